udp_rx_ch_packer: RTL and testbench
===================================

// Module: udp_rx_ch_packer
// PURPOSE
//  Sits after the udp block's receive user interface (rec_en/rec_data/rec_pkt_done) in the
//  UDP RX top. First payload byte of each packet selects a channel; remaining bytes are packed
//  big-endian into DATA_W-bit words and delivered on one of NUM_CH channels with keep/last.
//  Replaces the flat 8-bit rec_data output with a width- and channel-parametrised stream.
// PARAMETERS
//  DATA_W   32  output word width, multiple of 8, 8..64; LANES = DATA_W/8
//  NUM_CH   4   channel count, 1..256; channel ID byte >= NUM_CH is invalid
// PORTS
//  gmii_rx_clk   in   1        single clock (rx GMII clock)
//  rst_n         in   1        asynchronous, active-low reset
//  rec_en        in   1        payload byte valid (one byte/cycle max, no backpressure)
//  rec_data      in   8        payload byte
//  rec_pkt_done  in   1        1-cycle pulse, packet end; may coincide with last rec_en
//  out_valid     out  NUM_CH   one-hot beat strobe, bit = channel ID
//  out_data      out  DATA_W   packed word; first byte in bits [DATA_W-1 -: 8]
//  out_keep      out  LANES    lane valid, MSB lane = first byte; unused lanes data = 0
//  out_last      out  1        final beat of packet, qualified by |out_valid
//  err_bad_ch    out  1        1-cycle pulse: packet dropped (invalid ID or empty)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, lane count 0, hold register empty.
//  - All outputs registered; beat appears cycle after the event that releases it.
//  - FSM IDLE: rec_en -> latch rec_data as ch_id; id<NUM_CH -> PAYLOAD else DROP.
//    rec_pkt_done in IDLE (no bytes) -> err_bad_ch, stay IDLE.
//    rec_en+rec_pkt_done same cycle in IDLE -> ID-only packet: no beat, no error, IDLE.
//  - PAYLOAD: each rec_en byte written to lane (LANES-1-cnt); cnt wraps LANES-1 -> 0 and full
//    word moves to hold register. Hold is emitted (last=0, keep all 1) when the next byte
//    arrives, so the last full word is always available to carry out_last.
//  - PAYLOAD + rec_pkt_done (byte on same cycle accepted first):
//    partial lanes=0, hold valid -> emit hold, last=1 -> IDLE.
//    partial>0, hold empty -> emit partial, keep=top cnt lanes, last=1 -> IDLE.
//    partial>0, hold valid -> emit hold (last=0) -> FLUSH; next cycle partial (last=1) -> IDLE.
//    nothing held/partial (ID byte only) -> no beat -> IDLE.
//  - FLUSH: one cycle; rec_en here is impossible by UDP gap; if seen, byte is discarded.
//  - DROP: ignore rec_en; rec_pkt_done -> err_bad_ch pulse, IDLE.
//  - out_valid is one-hot or 0; never two beats in one cycle; no beat leaks across packets.
//  - Reset mid-packet: async clear, in-flight packet lost, no partial beat emitted.
// CONFIGURATION
//  UDP_RX_CH_STATS_EN defined: adds outputs stat_pkt_cnt[31:0] (packets delivered with >=1
//   beat), stat_drop_cnt[15:0] (err_bad_ch pulses, saturating at 16'hFFFF),
//   stat_byte_cnt[31:0] (payload bytes delivered, wrapping); all reset to 0, +1 cycle after
//   the out_last/err event. Undefined: ports and counters absent, behaviour otherwise same.
// TESTING
//  DATA_W=32: ID 02, payload 01..08 -> out_valid=4'b0100 beats 01020304/keep F/last0, then
//   05060708/keep F/last1.
//  ID 01, payload 01..05 -> 01020304/F/0, then FLUSH beat 05000000/keep 8/last1, ch 1.
//  ID 07 (NUM_CH=4), 10 bytes -> no out_valid, err_bad_ch one pulse at rec_pkt_done.
//  ID 00, 3 bytes AA BB CC with rec_pkt_done on last byte -> AABBCC00/keep E/last1.
//  rst_n low mid-PAYLOAD after 6 bytes -> outputs 0 immediately; next packet ID 03 4 bytes ->
//   single clean beat, last1, ch 3.
//  STATS_EN: 3 good + 2 bad packets -> pkt_cnt=3, drop_cnt=2, byte_cnt=sum of payloads.

Source files
------------

// File: rtl/udp_rx_ch_packer.sv
// Channelised UDP RX payload packer: first payload byte picks the channel, the rest is packed
// big-endian into DATA_W words with keep/last. Optional counters behind UDP_RX_CH_STATS_EN.
module udp_rx_ch_packer #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4
) (
  input  logic                  gmii_rx_clk,
  input  logic                  rst_n,
  input  logic                  rec_en,
  input  logic [7:0]            rec_data,
  input  logic                  rec_pkt_done,
  output logic [NUM_CH-1:0]     out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [DATA_W/8-1:0]   out_keep,
  output logic                  out_last,
  output logic                  err_bad_ch
`ifdef UDP_RX_CH_STATS_EN
  ,
  output logic [31:0]           stat_pkt_cnt,
  output logic [15:0]           stat_drop_cnt,
  output logic [31:0]           stat_byte_cnt
`endif
);

  localparam int LANES = DATA_W / 8;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LANES - 1);
  localparam logic [LANES-1:0] KEEP_ALL = '1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, FLUSH, DROP} state_t;

  state_t            state, state_n;
  logic [7:0]        ch_id, ch_id_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] part, part_n;
  logic [DATA_W-1:0] hold, hold_n;
  logic              hold_vld, hold_vld_n;
  logic [LANES-1:0]  flush_keep, flush_keep_n;

  logic [NUM_CH-1:0] valid_n;
  logic [DATA_W-1:0] data_n;
  logic [LANES-1:0]  keep_n;
  logic              last_n;
  logic              err_n;
  logic              emit;

  logic [DATA_W-1:0] acc_part;
  logic [CNT_W-1:0]  acc_cnt;
  logic              word_done;
  logic [CNT_W-1:0]  tail_cnt;
  logic [DATA_W-1:0] tail_part;
  logic              sec_vld;
  logic [DATA_W-1:0] sec_dat;
  logic [LANES-1:0]  sec_keep;

  function automatic logic [LANES-1:0] keep_top(input logic [CNT_W-1:0] n);
    return ~(KEEP_ALL >> n);
  endfunction

  always_comb begin
    state_n      = state;
    ch_id_n      = ch_id;
    cnt_n        = cnt;
    part_n       = part;
    hold_n       = hold;
    hold_vld_n   = hold_vld;
    flush_keep_n = flush_keep;
    emit         = 1'b0;
    data_n       = '0;
    keep_n       = '0;
    last_n       = 1'b0;
    err_n        = 1'b0;
    valid_n      = '0;

    // Candidate state after accepting this cycle's byte into the partial word.
    acc_part = part;
    acc_part[(LANES - 1 - int'(cnt)) * 8 +: 8] = rec_data;
    word_done = rec_en && (cnt == CNT_MAX);
    acc_cnt   = word_done ? '0 : cnt + CNT_W'(1);
    tail_cnt  = rec_en ? acc_cnt : cnt;
    tail_part = rec_en ? (word_done ? '0 : acc_part) : part;
    sec_vld   = word_done || (tail_cnt != '0);
    sec_dat   = word_done ? acc_part : tail_part;
    sec_keep  = word_done ? KEEP_ALL : keep_top(tail_cnt);

    case (state)
      IDLE: begin
        cnt_n      = '0;
        part_n     = '0;
        hold_vld_n = 1'b0;
        if (rec_en) begin
          ch_id_n = rec_data;
          if (!rec_pkt_done) begin
            state_n = ({1'b0, rec_data} < 9'(NUM_CH)) ? PAYLOAD : DROP;
          end
        end else if (rec_pkt_done) begin
          err_n = 1'b1;
        end
      end

      PAYLOAD: begin
        if (!rec_pkt_done) begin
          if (rec_en) begin
            if (hold_vld) begin
              emit   = 1'b1;
              data_n = hold;
              keep_n = KEEP_ALL;
            end
            if (word_done) begin
              hold_n     = acc_part;
              hold_vld_n = 1'b1;
              part_n     = '0;
              cnt_n      = '0;
            end else begin
              hold_vld_n = 1'b0;
              part_n     = acc_part;
              cnt_n      = acc_cnt;
            end
          end
        end else begin
          cnt_n      = '0;
          part_n     = '0;
          hold_vld_n = 1'b0;
          state_n    = IDLE;
          if (hold_vld) begin
            emit   = 1'b1;
            data_n = hold;
            keep_n = KEEP_ALL;
            last_n = !sec_vld;
            // Only one beat per cycle: the tail waits one cycle in the hold register.
            if (sec_vld) begin
              hold_n       = sec_dat;
              flush_keep_n = sec_keep;
              state_n      = FLUSH;
            end
          end else if (sec_vld) begin
            emit   = 1'b1;
            data_n = sec_dat;
            keep_n = sec_keep;
            last_n = 1'b1;
          end
        end
      end

      FLUSH: begin
        emit    = 1'b1;
        data_n  = hold;
        keep_n  = flush_keep;
        last_n  = 1'b1;
        state_n = IDLE;
      end

      DROP: begin
        if (rec_pkt_done) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      valid_n[i] = emit && (ch_id == 8'(i));
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch_id      <= '0;
      cnt        <= '0;
      part       <= '0;
      hold       <= '0;
      hold_vld   <= 1'b0;
      flush_keep <= '0;
      out_valid  <= '0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      err_bad_ch <= 1'b0;
    end else begin
      state      <= state_n;
      ch_id      <= ch_id_n;
      cnt        <= cnt_n;
      part       <= part_n;
      hold       <= hold_n;
      hold_vld   <= hold_vld_n;
      flush_keep <= flush_keep_n;
      out_valid  <= valid_n;
      out_data   <= data_n;
      out_keep   <= keep_n;
      out_last   <= last_n;
      err_bad_ch <= err_n;
    end
  end

`ifdef UDP_RX_CH_STATS_EN
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_cnt  <= '0;
      stat_drop_cnt <= '0;
      stat_byte_cnt <= '0;
    end else begin
      if (|out_valid && out_last) begin
        stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      end
      if (|out_valid) begin
        stat_byte_cnt <= stat_byte_cnt + 32'($countones(out_keep));
      end
      if (err_bad_ch && (stat_drop_cnt != 16'hFFFF)) begin
        stat_drop_cnt <= stat_drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_udp_rx_ch_packer.sv
// Directed bench for udp_rx_ch_packer: packet model feeds a beat scoreboard checked on output.
module tb_udp_rx_ch_packer;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int LANES  = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rec_en;
  logic [7:0]        rec_data;
  logic              rec_pkt_done;
  logic [NUM_CH-1:0] out_valid;
  logic [DATA_W-1:0] out_data;
  logic [LANES-1:0]  out_keep;
  logic              out_last;
  logic              err_bad_ch;
`ifdef UDP_RX_CH_STATS_EN
  logic [31:0]       stat_pkt_cnt;
  logic [15:0]       stat_drop_cnt;
  logic [31:0]       stat_byte_cnt;
  int                pkt_exp  = 0;
  int                byte_exp = 0;
`endif

  always #5 clk = ~clk;

  udp_rx_ch_packer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
    .gmii_rx_clk  (clk),
    .rst_n        (rst_n),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .err_bad_ch   (err_bad_ch)
`ifdef UDP_RX_CH_STATS_EN
    ,
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_drop_cnt (stat_drop_cnt),
    .stat_byte_cnt (stat_byte_cnt)
`endif
  );

  typedef struct packed {
    logic [NUM_CH-1:0] vld;
    logic [DATA_W-1:0] dat;
    logic [LANES-1:0]  keep;
    logic              last;
  } beat_t;

  beat_t      sb[$];
  beat_t      mon_e;
  logic [7:0] pl[$];
  int         errors   = 0;
  int         checks   = 0;
  int         err_seen = 0;
  int         err_exp  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (err_bad_ch === 1'b1) err_seen++;
    if (out_valid !== '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("beat_ch",   64'(out_valid), 64'(mon_e.vld));
        chk("beat_data", 64'(out_data),  64'(mon_e.dat));
        chk("beat_keep", 64'(out_keep),  64'(mon_e.keep));
        chk("beat_last", 64'(out_last),  64'(mon_e.last));
      end
    end
  end

  task automatic drive(input logic en, input logic [7:0] d, input logic done);
    @(negedge clk);
    rec_en       = en;
    rec_data     = d;
    rec_pkt_done = done;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  // Reference packing: chunk the payload into LANES-byte words, first byte in the MSB lane.
  task automatic model_pkt(input logic [7:0] id);
    beat_t b;
    int    n = pl.size();
    for (int i = 0; i < n; i += LANES) begin
      b.vld  = NUM_CH'(1) << id;
      b.dat  = '0;
      b.keep = '0;
      for (int j = 0; j < LANES; j++) begin
        if (i + j < n) begin
          b.dat[DATA_W - 1 - 8 * j -: 8] = pl[i + j];
          b.keep[LANES - 1 - j]          = 1'b1;
        end
      end
      b.last = (i + LANES >= n);
      sb.push_back(b);
    end
  endtask

  task automatic send_pkt(input logic [7:0] id, input bit done_on_last);
    int n = pl.size();
    if (id < NUM_CH) begin
      model_pkt(id);
`ifdef UDP_RX_CH_STATS_EN
      if (n > 0) begin
        pkt_exp++;
        byte_exp += n;
      end
`endif
    end else if (!(done_on_last && n == 0)) begin
      err_exp++;
    end
    drive(1'b1, id, done_on_last && n == 0);
    for (int i = 0; i < n; i++) drive(1'b1, pl[i], done_on_last && (i == n - 1));
    if (!done_on_last) drive(1'b0, 8'h00, 1'b1);
    idle(5);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("err_pulses", 64'(err_seen), 64'(err_exp));
  endtask

  initial begin
    rst_n        = 1'b0;
    rec_en       = 1'b0;
    rec_data     = 8'h00;
    rec_pkt_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(out_valid),  64'd0);
    chk("rst_data",  64'(out_data),   64'd0);
    chk("rst_keep",  64'(out_keep),   64'd0);
    chk("rst_last",  64'(out_last),   64'd0);
    chk("rst_err",   64'(err_bad_ch), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Two full words, done on its own cycle.
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_pkt(8'd2, 1'b0);
    // Full word held plus one-byte tail with done on the last byte: FLUSH path.
    pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt(8'd1, 1'b1);
    // Invalid channel: dropped, one error pulse.
    pl = {};
    for (int i = 0; i < 10; i++) pl.push_back(8'(8'h30 + i));
    send_pkt(8'd7, 1'b0);
    // Partial word only, done on last byte.
    pl = {8'hAA, 8'hBB, 8'hCC};
    send_pkt(8'd0, 1'b1);
    // Empty packet: done with no bytes.
    err_exp++;
    drive(1'b0, 8'h00, 1'b1);
    idle(4);
    chk("empty_err", 64'(err_seen), 64'(err_exp));
    // ID-only packets: no beat, no error (done with the ID, and done a cycle later).
    pl = {};
    send_pkt(8'd3, 1'b1);
    send_pkt(8'd1, 1'b0);
    send_pkt(8'd9, 1'b1);
    // Length sweep across word boundaries on every channel.
    for (int len = 1; len <= 9; len++) begin
      pl = {};
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(1, 255)));
      send_pkt(8'(len % NUM_CH), (len % 2) == 1);
    end
    // Back-to-back packets with minimal gap.
    pl = {8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(8'd3, 1'b1);

`ifdef UDP_RX_CH_STATS_EN
    idle(2);
    chk("stat_pkt",  64'(stat_pkt_cnt),  64'(pkt_exp));
    chk("stat_drop", 64'(stat_drop_cnt), 64'(err_exp));
    chk("stat_byte", 64'(stat_byte_cnt), 64'(byte_exp));
`endif

    // Reset in the middle of a payload: first word already out, tail must be lost.
    sb.push_back('{vld: NUM_CH'(1) << 2, dat: 32'h11121314, keep: 4'hF, last: 1'b0});
    drive(1'b1, 8'd2, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h11 + i), 1'b0);
    @(negedge clk);
    rec_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid),  64'd0);
    chk("midrst_data",  64'(out_data),   64'd0);
    chk("midrst_keep",  64'(out_keep),   64'd0);
    chk("midrst_last",  64'(out_last),   64'd0);
    chk("midrst_err",   64'(err_bad_ch), 64'd0);
    chk("midrst_sb",    64'(sb.size()),  64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt(8'd3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
